// File: rtl/write_back_unit_pkg.sv
// rtl/write_back_unit_pkg.sv - shared types and constants for the write-back unit
package write_back_unit_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPORT = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

    localparam logic [3:0] ECALL_CAUSE = 4'd3;

endpackage

// File: rtl/write_back_unit_mux.sv
// rtl/write_back_unit_mux.sv - N-to-1 result multiplexer, out-of-range select gives zero
module mux_n_to_1 #(
    parameter int NUM_SRC    = 5,
    parameter int DATA_WIDTH = 64,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*DATA_WIDTH-1:0] data_i,
    input  logic [SRC_W-1:0]              sel_i,
    output logic [DATA_WIDTH-1:0]         data_o
);

    // Select one slice; a select with no matching slice leaves the zero default.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_i == SRC_W'(k)) begin
                data_o = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - WB stage register, result select, ECALL halt FSM and retire counter
module write_back_unit
    import write_back_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 5,
    parameter int CNT_WIDTH  = 64,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_valid,
    input  logic                          i_flush,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
    input  logic [SRC_W-1:0]              i_result_src,
    input  logic [REG_ADDR_W-1:0]         i_rd_addr,
    input  logic                          i_reg_we,
    input  logic                          i_ecall_instr,
    input  logic                          i_a0_reg_lsb,
    input  logic                          i_halt_ack,
    output logic [DATA_WIDTH-1:0]         o_result,
    output logic [REG_ADDR_W-1:0]         o_rd_addr,
    output logic                          o_reg_we,
    output logic                          o_valid,
    output logic                          o_halt_req,
    output logic                          o_halt_a0,
    output logic [3:0]                    o_halt_cause,
    output logic                          o_halted,
    output logic [CNT_WIDTH-1:0]          o_retire_cnt
);

    wb_state_t                     state_q, state_d;
    logic                          valid_q;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_q;
    logic [SRC_W-1:0]              sel_q;
    logic [REG_ADDR_W-1:0]         rd_q;
    logic                          we_q;
    logic                          ecall_q;
    logic                          a0_q;
    logic                          halt_a0_q;
    logic [3:0]                    halt_cause_q;
    logic [CNT_WIDTH-1:0]          cnt_q;

    logic running;
    logic wb_valid;
    logic ecall_retire;
    logic capture;

    assign running      = (state_q == RUN);
    assign wb_valid     = valid_q & running;
    assign ecall_retire = wb_valid & ecall_q;
    // The instruction behind a retiring ECALL is squashed so nothing retires after it.
    assign capture      = i_valid & ~i_flush & running & ~ecall_retire;

    // Halt sequencing: report the ECALL, wait for the environment, then stop for good.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (ecall_retire) state_d = REPORT;
            REPORT:  if (i_halt_ack)   state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // WB stage register, halt latches and retire counter. The counter advances on the
    // same edge that loads a valid instruction, so it already includes the instruction
    // shown on o_valid in that cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= RUN;
            valid_q      <= 1'b0;
            src_q        <= '0;
            sel_q        <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            ecall_q      <= 1'b0;
            a0_q         <= 1'b0;
            halt_a0_q    <= 1'b0;
            halt_cause_q <= 4'd0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= capture;
            src_q   <= i_src_data;
            sel_q   <= i_result_src;
            rd_q    <= i_rd_addr;
            we_q    <= i_reg_we;
            ecall_q <= i_ecall_instr;
            a0_q    <= i_a0_reg_lsb;
            if (capture) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (ecall_retire) begin
                halt_a0_q    <= a0_q;
                halt_cause_q <= ECALL_CAUSE;
            end
        end
    end

    mux_n_to_1 #(
        .NUM_SRC   (NUM_SRC),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_result_mux (
        .data_i(src_q),
        .sel_i (sel_q),
        .data_o(o_result)
    );

    assign o_rd_addr    = rd_q;
    assign o_valid      = wb_valid;
    assign o_reg_we     = wb_valid & we_q & ~ecall_q & (rd_q != '0);
    assign o_halt_req   = (state_q == REPORT);
    assign o_halted     = (state_q == HALTED);
    assign o_halt_a0    = halt_a0_q;
    assign o_halt_cause = halt_cause_q;
    assign o_retire_cnt = cnt_q;

endmodule

// File: tb/tb_write_back_unit.sv
// tb/tb_write_back_unit.sv - self-checking bench for write_back_unit
module tb_write_back_unit;

    localparam logic [63:0] LD_DATA  = 64'hAAAA_5555_AAAA_5555;
    localparam logic [63:0] PC4_DATA = 64'h0000_0000_0000_1004;
    localparam logic [63:0] TGT_DATA = 64'h0000_0000_0000_2000;
    localparam logic [63:0] IMM_DATA = 64'hFFFF_FFFF_FFFF_FFF0;

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid, flush, reg_we, ecall, a0, ack;
    logic [63:0]   alu;
    logic [319:0]  src;
    logic [2:0]    sel;
    logic [4:0]    rd;
    logic [63:0]   res;
    logic [4:0]    rd_o;
    logic          we_o, valid_o, halt_req, halt_a0, halted;
    logic [3:0]    cause;
    logic [3:0]    cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign src = {IMM_DATA, TGT_DATA, PC4_DATA, LD_DATA, alu};

    write_back_unit #(
        .DATA_WIDTH(64),
        .REG_ADDR_W(5),
        .NUM_SRC   (5),
        .CNT_WIDTH (4)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_valid      (valid),
        .i_flush      (flush),
        .i_src_data   (src),
        .i_result_src (sel),
        .i_rd_addr    (rd),
        .i_reg_we     (reg_we),
        .i_ecall_instr(ecall),
        .i_a0_reg_lsb (a0),
        .i_halt_ack   (ack),
        .o_result     (res),
        .o_rd_addr    (rd_o),
        .o_reg_we     (we_o),
        .o_valid      (valid_o),
        .o_halt_req   (halt_req),
        .o_halt_a0    (halt_a0),
        .o_halt_cause (cause),
        .o_halted     (halted),
        .o_retire_cnt (cnt)
    );

    typedef struct {
        logic        v;
        logic        fl;
        logic        we;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic        ev;
        logic        ewe;
        logic        chkres;
        logic [63:0] eres;
    } vec_t;

    typedef struct {
        logic        v;
        logic        we;
        logic        chkres;
        logic [63:0] res;
        logic [4:0]  rd;
        logic [3:0]  cnt;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    logic [3:0] exp_cnt;
    logic [3:0] saved_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; flush = 1'b0; reg_we = 1'b0; ecall = 1'b0;
        a0 = 1'b0; ack = 1'b0; alu = 64'h0; sel = 3'd0; rd = 5'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        exp_t e;
        valid = v.v; flush = v.fl; reg_we = v.we; sel = v.sel; rd = v.rd; alu = v.alu;
        ecall = 1'b0; a0 = 1'b0;
        if (v.ev) exp_cnt = exp_cnt + 4'd1;
        e.v = v.ev; e.we = v.ewe; e.chkres = v.chkres; e.res = v.eres; e.rd = v.rd;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 64'(valid_o), 64'(e.v));
            chk({tag, "_we"}, 64'(we_o), 64'(e.we));
            chk({tag, "_rd"}, 64'(rd_o), 64'(e.rd));
            chk({tag, "_cnt"}, 64'(cnt), 64'(e.cnt));
            if (e.chkres) chk({tag, "_result"}, res, e.res);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        valid = 1'b1; reg_we = 1'b1; rd = 5'd9; alu = 64'hDEAD;
        tick();
        tick();
        rstn = 1'b1;
        idle_inputs();
        exp_cnt = 4'd0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd5,  64'h1234, 1'b1, 1'b1, 1'b1, 64'h1234};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd0,  64'hBEEF, 1'b1, 1'b0, 1'b1, 64'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd7,  64'h7777, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd0, 5'd8,  64'h8888, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 3'd1, 5'd3,  64'h1,    1'b1, 1'b1, 1'b1, LD_DATA};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 3'd2, 5'd31, 64'h2,    1'b1, 1'b0, 1'b1, PC4_DATA};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 3'd3, 5'd12, 64'h3,    1'b1, 1'b1, 1'b1, TGT_DATA};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 3'd4, 5'd13, 64'h4,    1'b1, 1'b1, 1'b1, IMM_DATA};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 3'd7, 5'd4,  64'h5,    1'b1, 1'b1, 1'b1, 64'h0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 3'd5, 5'd14, 64'h6,    1'b1, 1'b1, 1'b1, 64'h0};

        do_reset();
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_result", res, 64'd0);
        chk("rst_rd", 64'(rd_o), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_halt_req", 64'(halt_req), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_cause", 64'(cause), 64'd0);

        for (int i = 0; i < 10; i++) begin
            drive_vec(vecs[i]);
            if (i == 3) ack = 1'b1;
            tick();
            check_out($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_halt_req", i), 64'(halt_req), 64'd0);
        end

        saved_cnt = exp_cnt;
        for (int i = 0; i < 16; i++) begin
            vec_t w;
            w = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd1, 64'(i) + 64'h100, 1'b1, 1'b1, 1'b1, 64'(i) + 64'h100};
            drive_vec(w);
            tick();
            check_out($sformatf("wrap%0d", i));
        end
        chk("wrap_cnt_back", 64'(cnt), 64'(saved_cnt));

        idle_inputs();
        valid = 1'b1; ecall = 1'b1; a0 = 1'b1; reg_we = 1'b1; rd = 5'd10; alu = 64'h55;
        tick();
        chk("ecall_valid", 64'(valid_o), 64'd1);
        chk("ecall_no_write", 64'(we_o), 64'd0);
        chk("ecall_cnt", 64'(cnt), 64'(saved_cnt + 4'd1));
        chk("ecall_no_req_yet", 64'(halt_req), 64'd0);
        idle_inputs();
        valid = 1'b1; reg_we = 1'b1; rd = 5'd6; alu = 64'h99;
        tick();
        chk("post_ecall_req", 64'(halt_req), 64'd1);
        chk("post_ecall_a0", 64'(halt_a0), 64'd1);
        chk("post_ecall_cause", 64'(cause), 64'd3);
        chk("add_suppressed_valid", 64'(valid_o), 64'd0);
        chk("add_suppressed_we", 64'(we_o), 64'd0);
        chk("add_suppressed_cnt", 64'(cnt), 64'(saved_cnt + 4'd1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("report_hold%0d_req", i), 64'(halt_req), 64'd1);
            chk($sformatf("report_hold%0d_cnt", i), 64'(cnt), 64'(saved_cnt + 4'd1));
            chk($sformatf("report_hold%0d_halted", i), 64'(halted), 64'd0);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_halted", 64'(halted), 64'd1);
        chk("ack_req_drop", 64'(halt_req), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halted%0d_sticky", i), 64'(halted), 64'd1);
            chk($sformatf("halted%0d_valid", i), 64'(valid_o), 64'd0);
            chk($sformatf("halted%0d_we", i), 64'(we_o), 64'd0);
            chk($sformatf("halted%0d_cnt", i), 64'(cnt), 64'(saved_cnt + 4'd1));
            chk($sformatf("halted%0d_a0", i), 64'(halt_a0), 64'd1);
            chk($sformatf("halted%0d_cause", i), 64'(cause), 64'd3);
        end

        do_reset();
        valid = 1'b1; reg_we = 1'b1; rd = 5'd2; alu = 64'h11;
        tick();
        valid = 1'b1; ecall = 1'b1; a0 = 1'b0; rd = 5'd0;
        tick();
        idle_inputs();
        tick();
        chk("rpt2_req", 64'(halt_req), 64'd1);
        chk("rpt2_a0", 64'(halt_a0), 64'd0);
        chk("rpt2_cnt", 64'(cnt), 64'd2);
        rstn = 1'b0;
        tick();
        chk("midrst_req", 64'(halt_req), 64'd0);
        chk("midrst_halted", 64'(halted), 64'd0);
        chk("midrst_cnt", 64'(cnt), 64'd0);
        chk("midrst_cause", 64'(cause), 64'd0);
        rstn = 1'b1;
        valid = 1'b1; reg_we = 1'b1; rd = 5'd7; alu = 64'hCAFE;
        tick();
        chk("after_rst_valid", 64'(valid_o), 64'd1);
        chk("after_rst_we", 64'(we_o), 64'd1);
        chk("after_rst_result", res, 64'hCAFE);
        chk("after_rst_cnt", 64'(cnt), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
